// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } dmem_state_e;

    localparam int unsigned DefaultLatency   = 4;
    localparam int unsigned DefaultDepthLog2 = 8;
    localparam int unsigned DefaultLineWords = 4;
    // Latency counter width; covers the full 1..15 latency range.
    localparam int unsigned LatCntW          = 4;

endpackage

// File: rtl/dmem_if.sv
// Request/response bus between the data cache (master) and the memory responder (slave).
interface dmem_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_last;
    logic        resp_is_wr;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_last, resp_is_wr
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_last, resp_is_wr
    );

endinterface

// File: rtl/dmem_ram.sv
// Word-addressed storage: synchronous write, asynchronous read, contents not reset.
module dmem_ram #(
    parameter int unsigned DEPTH_LOG2 = 8
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] waddr_i,
    input  logic [31:0]           wdata_i,
    input  logic [DEPTH_LOG2-1:0] raddr_i,
    output logic [31:0]           rdata_o
);

    localparam int unsigned Depth = 1 << DEPTH_LOG2;

    logic [31:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency main-memory responder for the data cache.
// Define DMEM_BURST_EN to return whole cache lines (critical word first) on reads.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = DefaultDepthLog2,
    parameter int unsigned LATENCY    = DefaultLatency,
    parameter int unsigned LINE_WORDS = DefaultLineWords
) (
    input  logic   clk,
    input  logic   rst,
    dmem_if.slave  bus
);

    localparam int unsigned IdxW = DEPTH_LOG2;

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("LATENCY must be in 1..15");
    end
    if (LINE_WORDS == 0 || (LINE_WORDS & (LINE_WORDS - 1)) != 0) begin : g_bad_line
        $error("LINE_WORDS must be a power of 2");
    end

    dmem_state_e        state_q, state_d;
    logic [LatCntW-1:0] cnt_q, cnt_d;
    logic               wr_q, wr_d;
    logic [IdxW-1:0]    idx_q, idx_d;
    logic [IdxW-1:0]    rd_idx;
    logic [31:0]        ram_rdata;
    logic               accept;
    logic               resp_valid;
    logic               resp_hs;
    logic               beat_last;
    logic               unused_addr;

    // Byte-lane and out-of-range address bits are deliberately ignored (aliasing).
    assign unused_addr = ^{bus.req_addr[31:IdxW+2], bus.req_addr[1:0]};

`ifdef DMEM_BURST_EN
    localparam int unsigned OffW = $clog2(LINE_WORDS);

    if (LINE_WORDS < 2 || OffW >= IdxW) begin : g_bad_burst
        $error("burst line must hold 2+ words and fit inside the memory");
    end

    logic [OffW-1:0] beat_q, beat_d;
    logic [OffW-1:0] rd_off;

    // Offset wraps inside the aligned line, giving critical-word-first order.
    assign rd_off    = idx_q[OffW-1:0] + beat_q;
    assign rd_idx    = {idx_q[IdxW-1:OffW], rd_off};
    assign beat_last = wr_q | (beat_q == OffW'(LINE_WORDS - 1));
`else
    assign rd_idx    = idx_q;
    assign beat_last = 1'b1;
`endif

    assign bus.req_ready  = (state_q == StIdle) & ~rst;
    assign accept         = bus.req_valid & bus.req_ready;
    assign resp_valid     = (state_q == StResp) & ~rst;
    assign resp_hs        = resp_valid & bus.resp_ready;

    assign bus.resp_valid = resp_valid;
    assign bus.resp_last  = resp_valid & beat_last;
    assign bus.resp_is_wr = resp_valid & wr_q;
    assign bus.resp_rdata = (resp_valid & ~wr_q) ? ram_rdata : 32'h0;

    dmem_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (accept & bus.req_write),
        .waddr_i (bus.req_addr[IdxW+1:2]),
        .wdata_i (bus.req_wdata),
        .raddr_i (rd_idx),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        idx_d   = idx_q;
`ifdef DMEM_BURST_EN
        beat_d  = beat_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StWait;
                    cnt_d   = LatCntW'(LATENCY - 1);
                    wr_d    = bus.req_write;
                    idx_d   = bus.req_addr[IdxW+1:2];
`ifdef DMEM_BURST_EN
                    beat_d  = '0;
`endif
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StResp: begin
                if (resp_hs) begin
                    if (beat_last) begin
                        state_d = StIdle;
                    end
`ifdef DMEM_BURST_EN
                    else begin
                        beat_d = beat_q + 1'b1;
                    end
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
`ifdef DMEM_BURST_EN
            beat_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            idx_q   <= idx_d;
`ifdef DMEM_BURST_EN
            beat_q  <= beat_d;
`endif
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed scenarios plus randomized traffic.
module tb_dmem_responder;

    localparam int unsigned L     = 4;
    localparam int unsigned DL    = 8;
    localparam int unsigned LW    = 4;
    localparam int unsigned Depth = 1 << DL;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic        is_wr;
        int          first_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    dmem_if bus ();

    dmem_responder #(
        .DEPTH_LOG2 (DL),
        .LATENCY    (L),
        .LINE_WORDS (LW)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t        exp_q[$];
    logic [31:0] model_mem [Depth];
    int          tests = 0;
    int          fails = 0;
    bit          outstanding = 0;
    bit          chk_ready_next = 0;
    bit          chk_valid_next = 0;
    int          rr_mode = 0;

    function automatic void check(string name, logic [31:0] got, logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, want, cyc);
        end
    endfunction

    function automatic int word_of(logic [31:0] a);
        return int'((a >> 2) % Depth);
    endfunction

    // Response-ready driver: 0 = always ready, 1 = random, 2 = held low.
    initial begin
        bus.resp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rr_mode)
                0:       bus.resp_ready = 1'b1;
                1:       bus.resp_ready = 1'($urandom_range(0, 1));
                default: bus.resp_ready = 1'b0;
            endcase
        end
    end

    // Monitor: compares every presented beat with the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                check("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
                check("rst_req_ready", {31'b0, bus.req_ready}, 32'd0);
                chk_ready_next = 0;
                chk_valid_next = 0;
            end else begin
                if (chk_ready_next) begin
                    check("ready_after_last", {31'b0, bus.req_ready}, 32'd1);
                    chk_ready_next = 0;
                end else if (outstanding) begin
                    check("ready_low_busy", {31'b0, bus.req_ready}, 32'd0);
                end
                if (chk_valid_next) begin
                    check("beat_back_to_back", {31'b0, bus.resp_valid}, 32'd1);
                    chk_valid_next = 0;
                end
                if (bus.resp_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", {31'b0, bus.resp_valid}, 32'd0);
                    end else begin
                        check("resp_rdata", bus.resp_rdata, exp_q[0].data);
                        check("resp_last", {31'b0, bus.resp_last}, {31'b0, exp_q[0].last});
                        check("resp_is_wr", {31'b0, bus.resp_is_wr}, {31'b0, exp_q[0].is_wr});
                        if (exp_q[0].first_cyc >= 0) begin
                            check("first_beat_cycle", cyc, exp_q[0].first_cyc);
                            exp_q[0].first_cyc = -1;
                        end
                        if (bus.resp_ready) begin
                            if (exp_q[0].last) begin
                                outstanding    = 0;
                                chk_ready_next = 1;
                            end else begin
                                chk_valid_next = 1;
                            end
                            void'(exp_q.pop_front());
                        end
                    end
                end
            end
        end
    end

    // Issue one request; on acceptance update the model and queue expected beats.
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                         input bit track);
        int   n;
        int   first;
        int   w;
        int   base;
        exp_t e;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.req_ready && n < 50);
        if (!bus.req_ready) begin
            check("accept_timeout", {31'b0, bus.req_ready}, 32'd1);
            bus.req_valid = 1'b0;
            return;
        end
        first = cyc + 1 + L;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        w = word_of(addr);
        if (wr) model_mem[w] = wd;
        if (track) begin
            outstanding = 1;
            if (wr) begin
                e.data = 32'h0; e.last = 1'b1; e.is_wr = 1'b1; e.first_cyc = first;
                exp_q.push_back(e);
            end else begin
`ifdef DMEM_BURST_EN
                base = w - (w % LW);
                for (int k = 0; k < LW; k++) begin
                    e.data      = model_mem[base + ((w % LW) + k) % LW];
                    e.last      = (k == LW - 1);
                    e.is_wr     = 1'b0;
                    e.first_cyc = (k == 0) ? first : -1;
                    exp_q.push_back(e);
                end
`else
                base = w;
                e.data = model_mem[base]; e.last = 1'b1; e.is_wr = 1'b0; e.first_cyc = first;
                exp_q.push_back(e);
`endif
            end
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || outstanding) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || outstanding) begin
            check("drain_timeout", exp_q.size(), 32'd0);
            exp_q.delete();
            outstanding = 0;
        end
        @(negedge clk);
    endtask

    initial begin
        int          n;
        logic [31:0] a;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;
        rr_mode       = 0;

        // Reset then idle
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", {31'b0, bus.req_ready}, 32'd1);
        check("idle_resp_valid", {31'b0, bus.resp_valid}, 32'd0);

        // Write then read
        issue(1'b1, 32'h10, 32'hDEADBEEF, 1);
        wait_idle();
        issue(1'b0, 32'h10, 32'h0, 1);
        wait_idle();

        // Backpressure: hold the first beat for 6 cycles
        rr_mode = 2;
        issue(1'b0, 32'h10, 32'h0, 1);
        n = 0;
        while (!bus.resp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_beat_seen", {31'b0, bus.resp_valid}, 32'd1);
        repeat (6) @(negedge clk);
        rr_mode = 0;
        wait_idle();

        // Address aliasing
        issue(1'b1, 32'h404, 32'h1234, 1);
        wait_idle();
        issue(1'b0, 32'h004, 32'h0, 1);
        wait_idle();

        // Line read from 0x18 (wrapping burst when enabled)
        issue(1'b1, 32'h10, 32'hAAAA_0001, 1); wait_idle();
        issue(1'b1, 32'h14, 32'hBBBB_0002, 1); wait_idle();
        issue(1'b1, 32'h18, 32'hCCCC_0003, 1); wait_idle();
        issue(1'b1, 32'h1C, 32'hDDDD_0004, 1); wait_idle();
        issue(1'b0, 32'h18, 32'h0, 1);
        wait_idle();

        // Reset in WAIT after a write: no beat, but the write sticks
        issue(1'b1, 32'h80, 32'hCAFEF00D, 0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("idle_after_mid_rst_wr", {31'b0, bus.req_ready}, 32'd1);
        repeat (L + 3) @(negedge clk);
        issue(1'b0, 32'h80, 32'h0, 1);
        wait_idle();

        // Reset in WAIT after a read: that read never responds
        issue(1'b0, 32'h10, 32'h0, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("idle_after_mid_rst_rd", {31'b0, bus.req_ready}, 32'd1);
        repeat (L + 3) @(negedge clk);

        // Preload every word, with junk in the ignored address bits
        for (int w = 0; w < int'(Depth); w++) begin
            a = ($urandom & ~32'h3FC) | (32'(w) << 2);
            issue(1'b1, a, $urandom, 1);
            wait_idle();
        end

        // Randomized mix of reads and writes with random backpressure
        for (int t = 0; t < 300; t++) begin
            rr_mode = int'($urandom_range(0, 1));
            issue(($urandom_range(0, 2) == 0), $urandom, $urandom, 1);
            wait_idle();
        end
        rr_mode = 0;
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
